alu_seq_n: RTL and testbench
============================

// Module: alu_seq_n
// PURPOSE
//  Parametrised WIDTH-bit sequential ALU: bitwise, add/sub, shift and multi-cycle multiply.
//  Successor to the fixed 8-bit combinational logic units; adds registered outputs, flags and a
//  valid/ready handshake on both sides. Sits between operand source and result sink in the datapath.
// PARAMETERS
//  WIDTH  8  operand/result width; power of two, 4..32
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block accepts operands this cycle
//  op         in   3      operation select (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result registers hold a valid result
//  out_ready  in   1      sink takes result this cycle
//  z          out  WIDTH  result
//  carry      out  1      carry/borrow/shift-out/overflow flag
//  zero       out  1      1 when z == 0
//  err        out  1      unsupported op executed
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, in_ready=1 after release, out_valid=0, z=0, carry=0,
//    zero=0, err=0, mul counter=0. Any in-flight operation is discarded.
//  - FSM: IDLE -> (accept, op!=MUL) -> HOLD; IDLE -> (accept, op==MUL) -> MUL;
//    MUL -> (count==0) -> HOLD; HOLD -> (out_ready) -> IDLE.
//  - in_ready = (state==IDLE). Accept = in_valid & in_ready on a rising edge; a, b, op are
//    latched at accept; later changes on inputs are ignored until next accept.
//  - out_valid = (state==HOLD). z/carry/zero/err stay stable while out_valid & !out_ready.
//  - Latency: single-cycle ops -> out_valid high after the edge following accept (1 cycle).
//    MUL -> out_valid high WIDTH cycles after accept. Throughput max 1 result per 2 cycles.
//  - Opcodes (carry=0 unless stated):
//    000 AND  z=a&b        001 OR  z=a|b        010 XOR  z=a^b      011 NOT  z=~a
//    100 ADD  z=a+b mod 2^WIDTH, carry=bit WIDTH of sum
//    101 SUB  z=a-b mod 2^WIDTH, carry=1 when a<b (borrow), unsigned
//    110 SHL  z=a<<s, s=b[log2(WIDTH)-1:0]; carry=last bit shifted out, 0 when s=0
//    111 MUL  unsigned shift-and-add, one bit of b per cycle, z=low WIDTH bits of a*b,
//             carry=1 when any high WIDTH bit of the 2*WIDTH product is nonzero
//  - zero is computed from the final z, registered with it; err=0 for ops 000..110.
//  - out_ready while not out_valid has no effect. in_valid outside IDLE is ignored (not queued).
//  - rst asserted during MUL or HOLD: outputs clear immediately; result lost.
// CONFIGURATION
//  ALU_MUL_EN defined: op 111 runs the multi-cycle multiplier as above, err=0.
//  ALU_MUL_EN undefined: no multiplier/counter logic; op 111 completes with 1-cycle latency,
//    z=0, carry=0, zero=1, err=1; FSM never enters MUL.
// TESTING (WIDTH=8)
//  1 AND a=0x12 b=0x45 -> z=0x00 zero=1; AND a=0x16 b=0x55 -> z=0x14 zero=0; each 1 cycle.
//  2 ADD 0xF0+0x20 -> z=0x10 carry=1; SUB 0x10-0x20 -> z=0xF0 carry=1; SHL 0x81 by 1 -> z=0x02 carry=1.
//  3 MUL 0x0F*0x11 -> z=0xFF carry=0, out_valid exactly 8 cycles after accept;
//    MUL 0x10*0x10 -> z=0x00 carry=1 zero=1.
//  4 Backpressure: out_ready=0 for 5 cycles after result -> z/flags stable, in_ready=0,
//    in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//  5 rst pulse 3 cycles into a MUL -> out_valid=0 and z=0 immediately; after release next
//    ADD 0x01+0x01 -> z=0x02 with 1-cycle latency.
//  6 Build without ALU_MUL_EN: op 111 a=0x03 b=0x03 -> z=0x00 err=1 zero=1 after 1 cycle.

Source files
------------

// File: rtl/alu_seq_n.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_n
//  Purpose  : WIDTH-bit sequential ALU with registered result and flags and a
//             valid/ready handshake on both sides. It provides bitwise, add/sub
//             and shift-left operations in one cycle, plus an optional
//             shift-and-add multiplier that processes one bit of b per cycle.
//  Ports    : clk, rst (async, active-high)
//             in_valid / in_ready          operand handshake
//             op[2:0], a, b                operation and operands
//             out_valid / out_ready        result handshake
//             z, carry, zero, err          result and flags
//  Config   : ALU_MUL_EN - when defined, op 111 runs the WIDTH-cycle
//             multiplier. When undefined, op 111 returns z=0 with err=1 in one
//             cycle, and no multiplier logic is built.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam int c_SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;

    // Single-cycle result, computed from the operands present at accept
    logic [WIDTH-1:0] w_z;
    logic             w_carry;
    logic             w_err;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;

    assign w_sum = {1'b0, a} + {1'b0, b};
    // Bit WIDTH of the widened shift is the last bit pushed out (0 when s=0)
    assign w_shl = {1'b0, a} << b[c_SHW-1:0];

    always_comb begin
        w_z     = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (op)
            3'b000: w_z = a & b;
            3'b001: w_z = a | b;
            3'b010: w_z = a ^ b;
            3'b011: w_z = ~a;
            3'b100: {w_carry, w_z} = w_sum;
            3'b101: begin
                w_z     = a - b;
                w_carry = (a < b);
            end
            3'b110: {w_carry, w_z} = w_shl;
            default: begin
`ifdef ALU_MUL_EN
                w_err = 1'b0;
`else
                w_err = 1'b1;
`endif
            end
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_SHW-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_z      <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_MUL_EN
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MUL_EN
                        if (op == 3'b111) begin
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplier <= b;
                            r_cnt    <= c_SHW'(WIDTH - 1);
                            r_state  <= S_MUL;
                        end else
`endif
                        begin
                            r_z     <= w_z;
                            r_carry <= w_carry;
                            r_zero  <= (w_z == '0);
                            r_err   <= w_err;
                            r_state <= S_HOLD;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    // Last bit of b: the product is complete in w_acc_next
                    if (r_cnt == '0) begin
                        r_z     <= w_acc_next[WIDTH-1:0];
                        r_carry <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_zero  <= (w_acc_next[WIDTH-1:0] == '0);
                        r_err   <= 1'b0;
                        r_state <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_HOLD);
    assign z         = r_z;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_n
//  Purpose  : Self-checking bench for alu_seq_n (WIDTH=8). Directed vector
//             table plus hand-written backpressure and reset-abort sequences.
//             Multiplier vectors are used when ALU_MUL_EN is defined, the
//             err=1 response for op 111 otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_n;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             carry;
    logic             zero;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_n #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic       c;
        logic       zr;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] vz, input logic vc, input logic vzr,
                           input logic ve, input int vl);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.z = vz; v.c = vc; v.zr = vzr; v.e = ve; v.lat = vl;
        vecs.push_back(v);
    endtask

    // Present one operation, accept it, and measure cycles until out_valid.
    task automatic start_op(input string nm, input logic [2:0] o, input logic [7:0] va,
                            input logic [7:0] vb, input int exp_lat);
        int lat;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        op = o; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h5A; op = 3'b000;  // later input changes must be ignored
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic release_result(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " out_valid after take"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready after take"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string nm;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;

        // Directed vectors: op, a, b, z, carry, zero, err, latency
        add_vec(3'b000, 8'h12, 8'h45, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        add_vec(3'b000, 8'h16, 8'h55, 8'h14, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b001, 8'h12, 8'h45, 8'h57, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b010, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b011, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b100, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1);
        add_vec(3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        add_vec(3'b101, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, 1);
        add_vec(3'b101, 8'h20, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b101, 8'h33, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        add_vec(3'b110, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1);
        add_vec(3'b110, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b110, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b110, 8'h40, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        add_vec(3'b110, 8'h81, 8'h09, 8'h02, 1'b1, 1'b0, 1'b0, 1);
`ifdef ALU_MUL_EN
        add_vec(3'b111, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, WIDTH);
        add_vec(3'b111, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, WIDTH);
        add_vec(3'b111, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, WIDTH);
        add_vec(3'b111, 8'h00, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, WIDTH);
`else
        add_vec(3'b111, 8'h03, 8'h03, 8'h00, 1'b0, 1'b1, 1'b1, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset z", 32'(z), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        chk("post-reset out_valid", 32'(out_valid), 32'd0);
        chk("post-reset z", 32'(z), 32'd0);
        chk("post-reset carry", 32'(carry), 32'd0);
        chk("post-reset zero", 32'(zero), 32'd0);
        chk("post-reset err", 32'(err), 32'd0);

        // out_ready while idle must not matter
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle out_ready out_valid", 32'(out_valid), 32'd0);

        foreach (vecs[i]) begin
            nm = $sformatf("vec%0d op%0d", i, vecs[i].op);
            start_op(nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat);
            chk({nm, " z"}, 32'(z), 32'(vecs[i].z));
            chk({nm, " carry"}, 32'(carry), 32'(vecs[i].c));
            chk({nm, " zero"}, 32'(zero), 32'(vecs[i].zr));
            chk({nm, " err"}, 32'(err), 32'(vecs[i].e));
            release_result(nm);
        end

        // Backpressure: result held 5 cycles while in_valid pulses are ignored
        start_op("bp", 3'b100, 8'hF0, 8'h20, 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0]; op = 3'b001; a = 8'hFF; b = 8'hFF;
            @(posedge clk); #1;
            chk($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d z", k), 32'(z), 32'h10);
            chk($sformatf("bp%0d carry", k), 32'(carry), 32'd1);
        end
        in_valid = 1'b0;
        release_result("bp");
        @(posedge clk); #1;
        chk("bp no queued op", 32'(out_valid), 32'd0);

        // Reset mid-operation: outputs clear immediately, result lost
        start_op("pre-rst", 3'b100, 8'h12, 8'h34, 1);
        chk("pre-rst z", 32'(z), 32'h46);
        release_result("pre-rst");
`ifdef ALU_MUL_EN
        op = 3'b111; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
`else
        op = 3'b100; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst hold out_valid", 32'(out_valid), 32'd1);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst z", 32'(z), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("after rst out_valid", 32'(out_valid), 32'd0);
        start_op("post-rst add", 3'b100, 8'h01, 8'h01, 1);
        chk("post-rst add z", 32'(z), 32'h02);
        chk("post-rst add carry", 32'(carry), 32'd0);
        release_result("post-rst add");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
